fwd_hazard_ctrl: RTL and testbench
==================================

# fwd_hazard_ctrl

Forwarding and hazard controller for the register-bank operand stage. Tracks destination tags of the three in-flight instructions (EX, DM, WB), drives the A/B operand-source selects and immediate select of the operand block, and stalls decode on load-use hazards. Also sequences the register-bank write port: it supplies the DM-stage write address and its qualifier.

## Interface
- No parameters. Register address width is fixed at 5; operand-source width is fixed at 2.
- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- id_valid  in  1  decode stage holds a real instruction
- id_ra  in  5  source register A of decode instruction
- id_rb  in  5  source register B of decode instruction
- id_rw  in  5  destination register of decode instruction
- id_wr  in  1  decode instruction writes a register
- id_load  in  1  decode instruction is a load
- id_use_a  in  1  decode instruction reads RA
- id_use_b  in  1  decode instruction reads RB (ignored when id_imm)
- id_imm  in  1  operand B is the immediate
- flush  in  1  squash the decode instruction (branch taken)
- mux_sel_a  out  2  A source: 00 bank, 01 ans_ex, 10 ans_dm, 11 ans_wb
- mux_sel_b  out  2  B source, same encoding
- imm_sel  out  1  select immediate onto B
- stall  out  1  hold PC and decode register this cycle
- rw_dm  out  5  register-bank write address (DM stage)
- rw_dm_valid  out  1  DM-stage instruction writes rw_dm

## Operation
- Internal tag pipe: three slots EX, DM, WB, each {valid, wr, load, rw}. Each cycle: WB<=DM, DM<=EX, EX<=decode-insert.
- Decode-insert = {id_valid & ~stall & ~flush, id_wr, id_load, id_rw}; a stall or flush inserts a bubble (valid=0).
- Slot matches source r when valid & wr & rw==r & r!=0.
- Select for A (when id_use_a): EX match ->01; else DM match ->10; else WB match ->11; else 00. Same for B when id_use_b & ~id_imm. Unused operand -> 00. Register 0 always 00.
- Load-use: stall = id_valid & ~flush & EX.load & (EX matches used RA or used RB). During stall selects still drive their computed values; downstream ignores them.
- imm_sel = id_valid & id_imm (combinational).
- rw_dm = DM.rw; rw_dm_valid = DM.valid & DM.wr.
- Load data is available on ans_dm in DM stage, so one bubble is sufficient; after the stall the loader sits in DM and the select is 10.

## Timing
- Selects, imm_sel, stall: combinational from id_* and tag registers, same cycle.
- Tag pipe: one register per stage; instruction accepted at edge N is in EX during cycle N+1, DM N+2, WB N+3.
- Reset (async assert, sync release inside): all slots valid=0; rw_dm=0, rw_dm_valid=0; with id_valid=0 all selects 00, imm_sel 0, stall 0; stall counter 0.
- Reset mid-operation discards all tags; no forwarding from pre-reset instructions.
- flush and hazard same cycle: flush wins, stall=0, bubble inserted.
- Multiple matches: youngest (EX) wins.
- Back-to-back stalls impossible from one load; a second load-use against a new EX load stalls again.

## Configuration
- FWD_STALL_CNT_EN defined: adds output stall_cnt (16 bit), increments on each cycle with stall=1, saturates at 16'hFFFF, cleared by reset.
- Undefined: port and counter absent; behaviour otherwise identical.

## Structure
- Shared package: operand-source encodings (SRC_BANK, SRC_EX, SRC_DM, SRC_WB), register width constant, tag-slot struct.
- One sub-module: fwd_src_sel (combinational priority compare of one source against three slots, returns 2-bit select); instantiated twice.

## Test plan
- Reset with id_valid=0 -> all outputs 0, rw_dm_valid 0.
- ADD r3 then SUB using r3 as RA next cycle -> mux_sel_a=01; one cycle later rw_dm=3, rw_dm_valid=1.
- Writer of r5, two unrelated instrs, reader of r5 on RB -> mux_sel_b=11; with one gap -> 10.
- LOAD r7 then reader of r7 -> stall=1 one cycle, bubble in EX, next cycle mux_sel_a=10, stall=0; stall_cnt=1 when FWD_STALL_CNT_EN.
- Writer of r0 then reader of r0 -> selects 00; reader with id_imm=1 and RB=r3 hazard -> imm_sel=1, mux_sel_b=00, no stall.
- LOAD-use with flush asserted -> stall=0, bubble inserted; rst_n pulsed mid-stream -> tags cleared, next reader gets 00.

Source files
------------

// File: rtl/fwd_hazard_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fwd_hazard_ctrl_pkg
// Description : Shared types and constants for the forwarding / hazard
//               controller: operand-source encodings, register address width
//               and the in-flight tag-slot record.
// Revision    : 1.0 - initial release
// ============================================================================
package fwd_hazard_ctrl_pkg;

  localparam int REG_W = 5;
  localparam int SRC_W = 2;

  // Operand-source select encoding shared by the A and B operand muxes
  typedef enum logic [SRC_W-1:0] {
    SRC_BANK = 2'b00,
    SRC_EX   = 2'b01,
    SRC_DM   = 2'b10,
    SRC_WB   = 2'b11
  } src_sel_e;

  // One in-flight instruction as seen by the forwarding logic
  typedef struct packed {
    logic             valid;
    logic             wr;
    logic             load;
    logic [REG_W-1:0] rw;
  } tag_slot_t;

  // A slot can forward to source r only if it really writes r; r0 never forwards
  function automatic logic slot_match(input tag_slot_t s, input logic [REG_W-1:0] r);
    return s.valid & s.wr & (s.rw == r) & (r != '0);
  endfunction

endpackage
`default_nettype wire

// File: rtl/fwd_hazard_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : fwd_hazard_ctrl_if
// Description : Decode-side request and operand-block control bundle of the
//               forwarding / hazard controller. The stall_cnt member exists
//               only when FWD_STALL_CNT_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
interface fwd_hazard_ctrl_if;
  import fwd_hazard_ctrl_pkg::*;

  // Decode stage request
  logic             id_valid;
  logic [REG_W-1:0] id_ra;
  logic [REG_W-1:0] id_rb;
  logic [REG_W-1:0] id_rw;
  logic             id_wr;
  logic             id_load;
  logic             id_use_a;
  logic             id_use_b;
  logic             id_imm;
  logic             flush;

  // Operand block / pipeline control
  logic [SRC_W-1:0] mux_sel_a;
  logic [SRC_W-1:0] mux_sel_b;
  logic             imm_sel;
  logic             stall;
  logic [REG_W-1:0] rw_dm;
  logic             rw_dm_valid;
`ifdef FWD_STALL_CNT_EN
  logic [15:0]      stall_cnt;
`endif

  // Decode side: issues requests, consumes controls
  modport master (
    output id_valid, id_ra, id_rb, id_rw, id_wr, id_load,
           id_use_a, id_use_b, id_imm, flush,
    input  mux_sel_a, mux_sel_b, imm_sel, stall, rw_dm, rw_dm_valid
`ifdef FWD_STALL_CNT_EN
    , input stall_cnt
`endif
  );

  // Controller side
  modport slave (
    input  id_valid, id_ra, id_rb, id_rw, id_wr, id_load,
           id_use_a, id_use_b, id_imm, flush,
    output mux_sel_a, mux_sel_b, imm_sel, stall, rw_dm, rw_dm_valid
`ifdef FWD_STALL_CNT_EN
    , output stall_cnt
`endif
  );

endinterface
`default_nettype wire

// File: rtl/fwd_src_sel.sv
`default_nettype none
// ============================================================================
// Module      : fwd_src_sel
// Description : Priority compare of one source register against the EX, DM
//               and WB tag slots; the youngest matching slot wins.
// Revision    : 1.0 - initial release
// ============================================================================
module fwd_src_sel
  import fwd_hazard_ctrl_pkg::*;
(
  input  logic             use_i,
  input  logic [REG_W-1:0] reg_i,
  input  tag_slot_t        ex_i,
  input  tag_slot_t        dm_i,
  input  tag_slot_t        wb_i,
  output logic [SRC_W-1:0] sel_o
);

  // The load flag is irrelevant for source selection
  logic unused_load;
  assign unused_load = ^{ex_i.load, dm_i.load, wb_i.load};

  // Youngest-first priority; an unused operand always reads the bank
  always_comb begin
    sel_o = SRC_BANK;
    if (use_i) begin
      if (slot_match(ex_i, reg_i))      sel_o = SRC_EX;
      else if (slot_match(dm_i, reg_i)) sel_o = SRC_DM;
      else if (slot_match(wb_i, reg_i)) sel_o = SRC_WB;
    end
  end

endmodule
`default_nettype wire

// File: rtl/fwd_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : fwd_hazard_ctrl
// Description : Forwarding and hazard controller. Tracks destination tags of
//               the EX/DM/WB instructions, drives operand-source selects,
//               stalls decode on load-use, and supplies the DM-stage write
//               address. Optional stall counter enabled by FWD_STALL_CNT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module fwd_hazard_ctrl
  import fwd_hazard_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  fwd_hazard_ctrl_if.slave  bus
);

  tag_slot_t        ex_q, dm_q, wb_q;
  tag_slot_t        ex_d;
  logic [1:0]       rst_sync_q;
  logic             use_a, use_b;
  logic             haz_a, haz_b;
  logic             stall_w;
  logic [SRC_W-1:0] sel_a, sel_b;

  assign use_a = bus.id_use_a;
  assign use_b = bus.id_use_b & ~bus.id_imm;

  // Load-use: only the EX slot can hold a load whose data is not yet on a bus
  assign haz_a   = use_a & slot_match(ex_q, bus.id_ra);
  assign haz_b   = use_b & slot_match(ex_q, bus.id_rb);
  assign stall_w = bus.id_valid & ~bus.flush & ex_q.load & (haz_a | haz_b);

  // Decode insert; a stalled or flushed instruction enters EX as a bubble
  always_comb begin
    ex_d       = '0;
    ex_d.valid = bus.id_valid & ~stall_w & ~bus.flush;
    ex_d.wr    = bus.id_wr;
    ex_d.load  = bus.id_load;
    ex_d.rw    = bus.id_rw;
  end

  // Reset is taken asynchronously; release is held off two edges internally
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rst_sync_q <= 2'b00;
    else        rst_sync_q <= {rst_sync_q[0], 1'b1};
  end

  // Tag pipe advance: WB <= DM <= EX <= decode insert
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_q <= '0;
      dm_q <= '0;
      wb_q <= '0;
    end else if (!rst_sync_q[1]) begin
      ex_q <= '0;
      dm_q <= '0;
      wb_q <= '0;
    end else begin
      ex_q <= ex_d;
      dm_q <= ex_q;
      wb_q <= dm_q;
    end
  end

  fwd_src_sel u_sel_a (
    .use_i (use_a),
    .reg_i (bus.id_ra),
    .ex_i  (ex_q),
    .dm_i  (dm_q),
    .wb_i  (wb_q),
    .sel_o (sel_a)
  );

  fwd_src_sel u_sel_b (
    .use_i (use_b),
    .reg_i (bus.id_rb),
    .ex_i  (ex_q),
    .dm_i  (dm_q),
    .wb_i  (wb_q),
    .sel_o (sel_b)
  );

  assign bus.mux_sel_a   = sel_a;
  assign bus.mux_sel_b   = sel_b;
  assign bus.imm_sel     = bus.id_valid & bus.id_imm;
  assign bus.stall       = stall_w;
  assign bus.rw_dm       = dm_q.rw;
  assign bus.rw_dm_valid = dm_q.valid & dm_q.wr;

`ifdef FWD_STALL_CNT_EN
  logic [15:0] stall_cnt_q;
  logic [15:0] stall_cnt_d;

  // Saturating count of stalled cycles
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall_w && (stall_cnt_q != 16'hFFFF)) stall_cnt_d = stall_cnt_q + 16'd1;
  end

  // Stall counter register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) stall_cnt_q <= 16'd0;
    else        stall_cnt_q <= stall_cnt_d;
  end

  assign bus.stall_cnt = stall_cnt_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fwd_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_fwd_hazard_ctrl
// Description : Self-checking bench for fwd_hazard_ctrl: directed scenarios
//               plus randomized traffic against an in-bench reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fwd_hazard_ctrl;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  fwd_hazard_ctrl_if bus ();

  fwd_hazard_ctrl dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: list of the last three accepted instructions, index = age
  typedef struct {
    bit         v;
    bit         wr;
    bit         ld;
    logic [4:0] rw;
  } minst_t;

  minst_t m [3];

  // Source select from the rules: youngest in-flight writer of r, r0 never
  function automatic logic [1:0] m_sel(input bit use_r, input logic [4:0] r);
    m_sel = 2'd0;
    if (use_r && r != 5'd0)
      for (int age = 2; age >= 0; age--)
        if (m[age].v && m[age].wr && m[age].rw == r) m_sel = 2'(age + 1);
  endfunction

  function automatic bit m_stall();
    bit ua, ub;
    ua = bus.id_use_a;
    ub = bus.id_use_b && !bus.id_imm;
    m_stall = bus.id_valid && !bus.flush && m[0].v && m[0].ld &&
              (m_sel(ua, bus.id_ra) == 2'd1 || m_sel(ub, bus.id_rb) == 2'd1);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 3; i++) m[i] <= '{v: 1'b0, wr: 1'b0, ld: 1'b0, rw: 5'd0};
    end else begin
      m[2] <= m[1];
      m[1] <= m[0];
      m[0] <= '{v: bus.id_valid && !bus.flush && !m_stall(),
                wr: bus.id_wr, ld: bus.id_load, rw: bus.id_rw};
    end
  end

  // Apply one decode-stage cycle of inputs mid-cycle; outputs settle before the next edge
  task automatic drive(input bit v, input bit ld, input bit wr, input bit ua, input bit ub,
                       input bit imm, input bit fl,
                       input logic [4:0] ra, input logic [4:0] rb, input logic [4:0] rw);
    @(negedge clk);
    bus.id_valid = v;  bus.id_load  = ld; bus.id_wr = wr;
    bus.id_use_a = ua; bus.id_use_b = ub; bus.id_imm = imm; bus.flush = fl;
    bus.id_ra = ra; bus.id_rb = rb; bus.id_rw = rw;
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle(2);
    checks++;
    if (bus.mux_sel_a !== 2'd0 || bus.mux_sel_b !== 2'd0) begin
      failures++; $display("FAIL reset_sel got a=%0d b=%0d exp 0/0", bus.mux_sel_a, bus.mux_sel_b);
    end
    checks++;
    if (bus.imm_sel !== 1'b0 || bus.stall !== 1'b0) begin
      failures++; $display("FAIL reset_imm_stall got imm=%0b stall=%0b exp 0/0", bus.imm_sel, bus.stall);
    end
    checks++;
    if (bus.rw_dm !== 5'd0 || bus.rw_dm_valid !== 1'b0) begin
      failures++; $display("FAIL reset_rw_dm got rw=%0d v=%0b exp 0/0", bus.rw_dm, bus.rw_dm_valid);
    end
`ifdef FWD_STALL_CNT_EN
    checks++;
    if (bus.stall_cnt !== 16'd0) begin
      failures++; $display("FAIL reset_stall_cnt got %0d exp 0", bus.stall_cnt);
    end
`endif
    @(negedge clk);
    rst_n = 1'b1;
    idle(4);
  endtask

  task automatic test_fwd_ex();
    drive(1, 0, 1, 0, 0, 0, 0, 5'd1, 5'd2, 5'd3);          // ADD r3
    drive(1, 0, 1, 1, 1, 0, 0, 5'd3, 5'd4, 5'd6);          // SUB r6 = r3 - r4
    checks++;
    if (bus.mux_sel_a !== 2'b01 || bus.mux_sel_b !== 2'b00 || bus.stall !== 1'b0) begin
      failures++; $display("FAIL fwd_ex got a=%0d b=%0d stall=%0b exp 1/0/0",
                           bus.mux_sel_a, bus.mux_sel_b, bus.stall);
    end
    idle(1);
    checks++;
    if (bus.rw_dm !== 5'd3 || bus.rw_dm_valid !== 1'b1) begin
      failures++; $display("FAIL fwd_ex_rw_dm got rw=%0d v=%0b exp 3/1", bus.rw_dm, bus.rw_dm_valid);
    end
    idle(3);
  endtask

  task automatic test_fwd_dm_wb();
    drive(1, 0, 1, 0, 0, 0, 0, 5'd0, 5'd0, 5'd5);          // writer r5
    drive(1, 0, 1, 0, 0, 0, 0, 5'd0, 5'd0, 5'd1);
    drive(1, 0, 1, 0, 0, 0, 0, 5'd0, 5'd0, 5'd2);
    drive(1, 0, 0, 0, 1, 0, 0, 5'd0, 5'd5, 5'd0);          // reader of r5 on RB
    checks++;
    if (bus.mux_sel_b !== 2'b11) begin
      failures++; $display("FAIL fwd_wb got b=%0d exp 3", bus.mux_sel_b);
    end
    idle(3);
    drive(1, 0, 1, 0, 0, 0, 0, 5'd0, 5'd0, 5'd5);
    drive(1, 0, 1, 0, 0, 0, 0, 5'd0, 5'd0, 5'd1);
    drive(1, 0, 0, 0, 1, 0, 0, 5'd0, 5'd5, 5'd0);
    checks++;
    if (bus.mux_sel_b !== 2'b10) begin
      failures++; $display("FAIL fwd_dm got b=%0d exp 2", bus.mux_sel_b);
    end
    idle(3);
  endtask

  task automatic test_load_use();
`ifdef FWD_STALL_CNT_EN
    logic [15:0] cnt0;
    cnt0 = bus.stall_cnt;
`endif
    drive(1, 1, 1, 0, 0, 0, 0, 5'd0, 5'd0, 5'd7);          // LOAD r7
    drive(1, 0, 1, 1, 0, 0, 0, 5'd7, 5'd0, 5'd8);          // reader of r7
    checks++;
    if (bus.stall !== 1'b1 || bus.mux_sel_a !== 2'b01) begin
      failures++; $display("FAIL load_use_stall got stall=%0b a=%0d exp 1/1", bus.stall, bus.mux_sel_a);
    end
    drive(1, 0, 1, 1, 0, 0, 0, 5'd7, 5'd0, 5'd8);          // held reader
    checks++;
    if (bus.stall !== 1'b0 || bus.mux_sel_a !== 2'b10) begin
      failures++; $display("FAIL load_use_after got stall=%0b a=%0d exp 0/2", bus.stall, bus.mux_sel_a);
    end
    checks++;
    if (bus.rw_dm !== 5'd7 || bus.rw_dm_valid !== 1'b1) begin
      failures++; $display("FAIL load_use_rw_dm got rw=%0d v=%0b exp 7/1", bus.rw_dm, bus.rw_dm_valid);
    end
    idle(1);
    checks++;
    if (bus.rw_dm_valid !== 1'b0) begin
      failures++; $display("FAIL load_use_bubble got v=%0b exp 0", bus.rw_dm_valid);
    end
    idle(1);
    checks++;
    if (bus.rw_dm !== 5'd8 || bus.rw_dm_valid !== 1'b1) begin
      failures++; $display("FAIL load_use_reader got rw=%0d v=%0b exp 8/1", bus.rw_dm, bus.rw_dm_valid);
    end
`ifdef FWD_STALL_CNT_EN
    checks++;
    if (bus.stall_cnt !== cnt0 + 16'd1) begin
      failures++; $display("FAIL stall_cnt got %0d exp %0d", bus.stall_cnt, cnt0 + 16'd1);
    end
`endif
    idle(3);
  endtask

  task automatic test_r0_imm();
    drive(1, 0, 1, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0);          // writer of r0
    drive(1, 0, 0, 1, 1, 0, 0, 5'd0, 5'd0, 5'd0);
    checks++;
    if (bus.mux_sel_a !== 2'b00 || bus.mux_sel_b !== 2'b00) begin
      failures++; $display("FAIL r0 got a=%0d b=%0d exp 0/0", bus.mux_sel_a, bus.mux_sel_b);
    end
    idle(3);
    drive(1, 1, 1, 0, 0, 0, 0, 5'd0, 5'd0, 5'd3);          // LOAD r3
    drive(1, 0, 1, 1, 1, 1, 0, 5'd1, 5'd3, 5'd4);          // imm op, RB = r3
    checks++;
    if (bus.imm_sel !== 1'b1 || bus.mux_sel_b !== 2'b00 || bus.stall !== 1'b0) begin
      failures++; $display("FAIL imm got imm=%0b b=%0d stall=%0b exp 1/0/0",
                           bus.imm_sel, bus.mux_sel_b, bus.stall);
    end
    drive(0, 0, 0, 0, 0, 1, 0, 5'd0, 5'd0, 5'd0);
    checks++;
    if (bus.imm_sel !== 1'b0) begin
      failures++; $display("FAIL imm_invalid got %0b exp 0", bus.imm_sel);
    end
    idle(3);
  endtask

  task automatic test_flush();
    drive(1, 1, 1, 0, 0, 0, 0, 5'd0, 5'd0, 5'd9);          // LOAD r9
    drive(1, 0, 1, 1, 0, 0, 1, 5'd9, 5'd0, 5'd10);         // reader, flushed
    checks++;
    if (bus.stall !== 1'b0) begin
      failures++; $display("FAIL flush_stall got %0b exp 0", bus.stall);
    end
    drive(1, 0, 0, 1, 0, 0, 0, 5'd10, 5'd0, 5'd0);         // reader of flushed dest
    checks++;
    if (bus.mux_sel_a !== 2'b00 || bus.rw_dm !== 5'd9 || bus.rw_dm_valid !== 1'b1) begin
      failures++; $display("FAIL flush_bubble got a=%0d rw=%0d v=%0b exp 0/9/1",
                           bus.mux_sel_a, bus.rw_dm, bus.rw_dm_valid);
    end
    idle(1);
    checks++;
    if (bus.rw_dm_valid !== 1'b0) begin
      failures++; $display("FAIL flush_dm got v=%0b exp 0", bus.rw_dm_valid);
    end
    idle(3);
  endtask

  task automatic test_midreset();
    drive(1, 0, 1, 0, 0, 0, 0, 5'd0, 5'd0, 5'd4);
    drive(1, 0, 1, 0, 0, 0, 0, 5'd0, 5'd0, 5'd11);
    @(negedge clk);
    rst_n = 1'b0;
    bus.id_valid = 1; bus.id_load = 0; bus.id_wr = 0; bus.id_use_a = 1; bus.id_use_b = 1;
    bus.id_imm = 0; bus.flush = 0; bus.id_ra = 5'd4; bus.id_rb = 5'd11; bus.id_rw = 5'd0;
    #1;
    checks++;
    if (bus.mux_sel_a !== 2'b00 || bus.mux_sel_b !== 2'b00 || bus.rw_dm_valid !== 1'b0) begin
      failures++; $display("FAIL midreset got a=%0d b=%0d v=%0b exp 0/0/0",
                           bus.mux_sel_a, bus.mux_sel_b, bus.rw_dm_valid);
    end
    @(negedge clk);
    rst_n = 1'b1;
    drive(1, 0, 0, 1, 1, 0, 0, 5'd4, 5'd11, 5'd0);
    checks++;
    if (bus.mux_sel_a !== 2'b00 || bus.mux_sel_b !== 2'b00) begin
      failures++; $display("FAIL after_reset got a=%0d b=%0d exp 0/0", bus.mux_sel_a, bus.mux_sel_b);
    end
    idle(4);
  endtask

  task automatic test_random();
    bit v, ld, wr, ua, ub, imm, fl;
    logic [4:0] ra, rb, rw;
    for (int n = 0; n < 600; n++) begin
      v   = ($urandom_range(0, 7) != 0);
      ld  = ($urandom_range(0, 2) == 0);
      wr  = ($urandom_range(0, 4) != 0);
      ua  = ($urandom_range(0, 3) != 0);
      ub  = ($urandom_range(0, 3) != 0);
      imm = ($urandom_range(0, 4) == 0);
      fl  = ($urandom_range(0, 9) == 0);
      ra  = 5'($urandom_range(0, 7));
      rb  = 5'($urandom_range(0, 7));
      rw  = 5'($urandom_range(0, 7));
      drive(v, ld, wr, ua, ub, imm, fl, ra, rb, rw);
      checks++;
      if (bus.mux_sel_a !== m_sel(bus.id_use_a, bus.id_ra)) begin
        failures++; $display("FAIL rnd_sel_a n=%0d got %0d exp %0d", n, bus.mux_sel_a, m_sel(bus.id_use_a, bus.id_ra));
      end
      checks++;
      if (bus.mux_sel_b !== m_sel(bus.id_use_b && !bus.id_imm, bus.id_rb)) begin
        failures++; $display("FAIL rnd_sel_b n=%0d got %0d exp %0d", n, bus.mux_sel_b,
                             m_sel(bus.id_use_b && !bus.id_imm, bus.id_rb));
      end
      checks++;
      if (bus.stall !== m_stall()) begin
        failures++; $display("FAIL rnd_stall n=%0d got %0b exp %0b", n, bus.stall, m_stall());
      end
      checks++;
      if (bus.imm_sel !== (v && imm)) begin
        failures++; $display("FAIL rnd_imm n=%0d got %0b exp %0b", n, bus.imm_sel, v && imm);
      end
      checks++;
      if (bus.rw_dm !== m[1].rw || bus.rw_dm_valid !== (m[1].v && m[1].wr)) begin
        failures++; $display("FAIL rnd_rw_dm n=%0d got rw=%0d v=%0b exp %0d/%0b", n,
                             bus.rw_dm, bus.rw_dm_valid, m[1].rw, m[1].v && m[1].wr);
      end
    end
    idle(3);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    bus.id_valid = 0; bus.id_load = 0; bus.id_wr = 0; bus.id_use_a = 0; bus.id_use_b = 0;
    bus.id_imm = 0; bus.flush = 0; bus.id_ra = 5'd0; bus.id_rb = 5'd0; bus.id_rw = 5'd0;
    test_reset();
    test_fwd_ex();
    test_fwd_dm_wb();
    test_load_use();
    test_r0_imm();
    test_flush();
    test_midreset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
